// File: rtl/lif_neuron_if.sv
`default_nettype none
// ============================================================================
// Module      : lif_neuron_if
// Description : Control/status bundle between a neuron driver and a
//               lif_neuron instance.
// Revision    : 1.0 - initial release
// ============================================================================
interface lif_neuron_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic [WIDTH-1:0] current_in;
    logic             current_valid;
    logic [WIDTH-1:0] thresh;
    logic             clear_count;
    logic             spike;
    logic [WIDTH-1:0] membrane;
    logic             refractory;
    logic [7:0]       spike_count;

    // Driver side: produces stimulus, observes neuron state
    modport master (
        output ena, current_in, current_valid, thresh, clear_count,
        input  spike, membrane, refractory, spike_count
    );

    // Neuron side
    modport slave (
        input  ena, current_in, current_valid, thresh, clear_count,
        output spike, membrane, refractory, spike_count
    );
endinterface
`default_nettype wire

// File: rtl/lif_neuron.sv
`default_nettype none
// ============================================================================
// Module      : lif_neuron
// Description : Leaky integrate-and-fire neuron with shift-based leak,
//               saturating integration, refractory blanking and a wrapping
//               8-bit spike counter. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron #(
    parameter int WIDTH             = 8,
    parameter int THRESHOLD_DEFAULT = 200,
    parameter int LEAK_SHIFT        = 3,
    parameter int REFRACT_CYCLES    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    lif_neuron_if.slave  bus
);

    // Phase is implied by the refractory counter, not stored separately
    localparam logic [0:0] c_st_integrate  = 1'b0;
    localparam logic [0:0] c_st_refractory = 1'b1;

    localparam logic [WIDTH-1:0] c_thresh_default = WIDTH'(THRESHOLD_DEFAULT);
    localparam logic [3:0]       c_refract_load   = 4'(REFRACT_CYCLES);
    localparam logic [WIDTH-1:0] c_v_max          = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_membrane;
    logic             r_spike;
    logic [3:0]       r_rc;
    logic [7:0]       r_spike_count;

    logic [0:0]       w_state;
    logic [WIDTH-1:0] w_leak;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_v_next;
    logic [WIDTH-1:0] w_thresh;
    logic             w_fire;

    // Next membrane value, effective threshold and firing decision
    always_comb begin
        w_state  = (r_rc != 4'd0) ? c_st_refractory : c_st_integrate;
        w_leak   = r_membrane >> LEAK_SHIFT;
        // One extra bit holds the carry so saturation can be detected;
        // the leak never exceeds v, so the subtraction cannot underflow.
        w_sum    = {1'b0, r_membrane} - {1'b0, w_leak}
                 + (bus.current_valid ? {1'b0, bus.current_in} : {(WIDTH+1){1'b0}});
        w_v_next = w_sum[WIDTH] ? c_v_max : w_sum[WIDTH-1:0];
        w_thresh = (bus.thresh == '0) ? c_thresh_default : bus.thresh;
        w_fire   = (w_v_next >= w_thresh);
    end

    // Neuron state update: integrate/fire, refractory blanking, counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_membrane    <= '0;
            r_spike       <= 1'b0;
            r_rc          <= 4'd0;
            r_spike_count <= 8'd0;
        end else if (!bus.ena) begin
            // Frozen, but the pulse must not stretch across a stall
            r_spike <= 1'b0;
        end else begin
            case (w_state)
                c_st_integrate: begin
                    if (w_fire) begin
                        r_spike       <= 1'b1;
                        r_membrane    <= '0;
                        r_rc          <= c_refract_load;
                        r_spike_count <= r_spike_count + 8'd1;
                    end else begin
                        r_spike    <= 1'b0;
                        r_membrane <= w_v_next;
                    end
                end
                c_st_refractory: begin
                    r_spike    <= 1'b0;
                    r_membrane <= '0;
                    r_rc       <= r_rc - 4'd1;
                end
                default: begin
                    r_spike <= 1'b0;
                end
            endcase
            // Clear takes priority over a coincident increment
            if (bus.clear_count) begin
                r_spike_count <= 8'd0;
            end
        end
    end

    assign bus.spike       = r_spike;
    assign bus.membrane    = r_membrane;
    assign bus.refractory  = (r_rc != 4'd0);
    assign bus.spike_count = r_spike_count;

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_neuron
// Description : Self-checking bench for lif_neuron: directed scenarios plus
//               randomized traffic against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_neuron;

    logic clk;
    logic rst_n;

    lif_neuron_if #(.WIDTH(8)) bus ();

    lif_neuron #(
        .WIDTH             (8),
        .THRESHOLD_DEFAULT (200),
        .LEAK_SHIFT        (3),
        .REFRACT_CYCLES    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state in plain integers
    int  m_v;
    int  m_rc;
    int  m_cnt;
    int  m_spk;

    task automatic model_reset();
        m_v = 0; m_rc = 0; m_cnt = 0; m_spk = 0;
    endtask

    task automatic model_edge(input int e, input int cv, input int cur,
                              input int th, input int clr);
        int s;
        int t;
        if (e == 0) begin
            m_spk = 0;
        end else begin
            if (m_rc > 0) begin
                m_rc  = m_rc - 1;
                m_v   = 0;
                m_spk = 0;
            end else begin
                s = m_v - (m_v / 8) + ((cv != 0) ? cur : 0);
                if (s > 255) s = 255;
                t = (th == 0) ? 200 : th;
                if (s >= t) begin
                    m_spk = 1;
                    m_v   = 0;
                    m_rc  = 4;
                    m_cnt = (m_cnt + 1) % 256;
                end else begin
                    m_spk = 0;
                    m_v   = s;
                end
            end
            if (clr != 0) m_cnt = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".spike"},       {31'd0, bus.spike},        32'(m_spk));
        check({tag, ".membrane"},    {24'd0, bus.membrane},     32'(m_v));
        check({tag, ".refractory"},  {31'd0, bus.refractory},   32'(m_rc != 0));
        check({tag, ".spike_count"}, {24'd0, bus.spike_count},  32'(m_cnt));
    endtask

    task automatic step(input string tag, input logic e, input logic cv,
                        input logic [7:0] cur, input logic [7:0] th, input logic clr);
        bus.ena           = e;
        bus.current_valid = cv;
        bus.current_in    = cur;
        bus.thresh        = th;
        bus.clear_count   = clr;
        @(posedge clk);
        model_edge(int'(e), int'(cv), int'(cur), int'(th), int'(clr));
        #1;
        check_model(tag);
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before any edge
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, ".spike"},       {31'd0, bus.spike},       32'd0);
        check({tag, ".membrane"},    {24'd0, bus.membrane},    32'd0);
        check({tag, ".refractory"},  {31'd0, bus.refractory},  32'd0);
        check({tag, ".spike_count"}, {24'd0, bus.spike_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        rst_n             = 1'b1;
        bus.ena           = 1'b0;
        bus.current_valid = 1'b0;
        bus.current_in    = 8'd0;
        bus.thresh        = 8'd0;
        bus.clear_count   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        async_reset("reset");

        // Integrate to fire: 100, 188, then 265 saturates and fires
        step("itf1", 1, 1, 100, 0, 0);
        check("itf1.v", {24'd0, bus.membrane}, 32'd100);
        step("itf2", 1, 1, 100, 0, 0);
        check("itf2.v", {24'd0, bus.membrane}, 32'd188);
        step("itf3", 1, 1, 100, 0, 0);
        check("itf3.spike", {31'd0, bus.spike}, 32'd1);
        check("itf3.refr",  {31'd0, bus.refractory}, 32'd1);
        check("itf3.cnt",   {24'd0, bus.spike_count}, 32'd1);

        // Refractory blanking: four zeroed edges, then integration resumes
        for (int i = 0; i < 4; i++) begin
            step("blank", 1, 1, 100, 0, 0);
            check("blank.v", {24'd0, bus.membrane}, 32'd0);
        end
        check("blank.refr_end", {31'd0, bus.refractory}, 32'd0);
        step("resume1", 1, 1, 100, 0, 0);
        check("resume1.v", {24'd0, bus.membrane}, 32'd100);
        step("resume2", 1, 1, 100, 0, 0);
        step("refire", 1, 1, 100, 0, 0);
        check("refire.spike", {31'd0, bus.spike}, 32'd1);
        check("refire.cnt",   {24'd0, bus.spike_count}, 32'd2);

        // Drain refractory, then leak only: 160, 140, 123, 108
        for (int i = 0; i < 4; i++) step("drain", 1, 0, 0, 0, 0);
        step("leak0", 1, 1, 160, 0, 0);
        check("leak0.v", {24'd0, bus.membrane}, 32'd160);
        step("leak1", 1, 0, 0, 0, 0);
        check("leak1.v", {24'd0, bus.membrane}, 32'd140);
        step("leak2", 1, 0, 0, 0, 0);
        check("leak2.v", {24'd0, bus.membrane}, 32'd123);
        step("leak3", 1, 0, 0, 0, 0);
        check("leak3.v", {24'd0, bus.membrane}, 32'd108);

        // Enable freeze at 188, fire on first re-enabled edge
        async_reset("rst_freeze");
        step("fz_a", 1, 1, 100, 0, 0);
        step("fz_b", 1, 1, 100, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step("freeze", 0, 1, 100, 0, 0);
            check("freeze.v", {24'd0, bus.membrane}, 32'd188);
        end
        step("unfreeze", 1, 1, 100, 0, 0);
        check("unfreeze.spike", {31'd0, bus.spike}, 32'd1);

        // Reset while rc==2; first edge after release integrates from 0
        step("rc3", 1, 1, 100, 0, 0);
        step("rc2", 1, 1, 100, 0, 0);
        async_reset("rst_mid_refr");
        step("post_rst", 1, 1, 100, 0, 0);
        check("post_rst.v", {24'd0, bus.membrane}, 32'd100);

        // Clear coincident with a spike edge wins
        step("cl_a", 1, 1, 100, 0, 0);
        step("cl_fire1", 1, 1, 100, 0, 0);
        for (int i = 0; i < 4; i++) step("cl_blank", 1, 1, 100, 0, 0);
        step("cl_b", 1, 1, 100, 0, 0);
        step("cl_c", 1, 1, 100, 0, 0);
        step("cl_fire2", 1, 1, 100, 0, 1);
        check("clr_spike.spike", {31'd0, bus.spike}, 32'd1);
        check("clr_spike.cnt",   {24'd0, bus.spike_count}, 32'd0);

        // Clear while disabled has no effect
        for (int i = 0; i < 4; i++) step("cd_blank", 1, 1, 100, 0, 0);
        step("cd_a", 1, 1, 100, 0, 0);
        step("cd_b", 1, 1, 100, 0, 0);
        step("cd_fire", 1, 1, 100, 0, 0);
        step("clr_dis", 0, 0, 0, 0, 1);
        check("clr_dis.cnt", {24'd0, bus.spike_count}, 32'd1);

        // Counter wrap with thresh=1 and saturating input
        async_reset("rst_wrap");
        guard = 0;
        while (m_cnt != 255 && guard < 2000) begin
            step("wrap_run", 1, 1, 255, 1, 0);
            guard++;
        end
        check("wrap.at255", {24'd0, bus.spike_count}, 32'd255);
        guard = 0;
        do begin
            step("wrap_next", 1, 1, 255, 1, 0);
            guard++;
        end while (m_spk == 0 && guard < 10);
        check("wrap.spike", {31'd0, bus.spike}, 32'd1);
        check("wrap.cnt0",  {24'd0, bus.spike_count}, 32'd0);

        // Randomized traffic against the model
        async_reset("rst_rand");
        for (int i = 0; i < 1500; i++) begin
            logic       e, cv, clr;
            logic [7:0] cur, th;
            e   = ($urandom_range(0, 9) != 0);
            cv  = ($urandom_range(0, 3) != 0);
            cur = 8'($urandom_range(0, 255));
            th  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            clr = ($urandom_range(0, 49) == 0);
            step("rand", e, cv, cur, th, clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
